// File: rtl/matrix_entry_if.sv
// matrix_entry_if: bundles the element-entry handshake and the commit bus of
// matrix_entry_assembler.
//   master : user-input side; drives start/dims/abort/element, observes status
//   slave  : assembler side; consumes the request, drives ready/commit/status
//   start, dimXIn, dimYIn      new matrix request with its dimensions
//   abort                      cancel the matrix in progress
//   elemValid, elemData        element offer (row-major order)
//   elemReady                  element accepted when elemValid && elemReady
//   writeEnable                one-cycle commit strobe towards storage
//   dimX, dimY, writeData      latched dimensions and packed matrix
//   elemCount, busy, errCode   progress and status
interface matrix_entry_if #(
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_ELEM   = 25
);
  logic                           start;
  logic [7:0]                     dimXIn;
  logic [7:0]                     dimYIn;
  logic                           abort;
  logic                           elemValid;
  logic [ELEM_WIDTH-1:0]          elemData;
  logic                           elemReady;
  logic                           writeEnable;
  logic [7:0]                     dimX;
  logic [7:0]                     dimY;
  logic [MAX_ELEM*ELEM_WIDTH-1:0] writeData;
  logic [4:0]                     elemCount;
  logic                           busy;
  logic [1:0]                     errCode;

  modport master (
    output start, dimXIn, dimYIn, abort, elemValid, elemData,
    input  elemReady, writeEnable, dimX, dimY, writeData, elemCount, busy, errCode
  );

  modport slave (
    input  start, dimXIn, dimYIn, abort, elemValid, elemData,
    output elemReady, writeEnable, dimX, dimY, writeData, elemCount, busy, errCode
  );
endinterface

// File: rtl/matrix_entry_assembler.sv
// matrix_entry_assembler: collects one matrix element by element and packs it
// row-major into a flat word (element k at [k*ELEM_WIDTH +: ELEM_WIDTH]), then
// raises a one-cycle writeEnable for the storage block.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    matrix_entry_if.slave (request/element inputs, commit/status outputs)
// Build option: define RANGE_CHECK_EN to reject elements greater than MAX_VAL
// (errCode 2, matrix dropped). Without it every element value is accepted.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE    | waiting for start; dims checked on accepted start
// S_COLLECT | accepting elements until dimX*dimY have arrived
// S_COMMIT  | writeEnable high for this single cycle
// S_ERROR   | one-cycle stop after bad dims or out-of-range element
module matrix_entry_assembler #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_ELEM   = MAX_DIM * MAX_DIM,
  parameter int MAX_VAL    = 9
) (
  input logic            clk,
  input logic            rst_n,
  matrix_entry_if.slave  bus
);

`ifdef RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]                     dim_x;
  logic [7:0]                     dim_y;
  logic [4:0]                     elem_count;
  logic [MAX_ELEM*ELEM_WIDTH-1:0] data_q;
  logic [1:0]                     err_q;

  logic [4:0] target;
  logic       last_elem;
  logic       dims_ok;
  logic       elem_bad;

  logic load_start;
  logic set_dim_err;
  logic set_range_err;
  logic store_elem;
  logic clear_count;

  // Dims are only meaningful here once validated to 1..MAX_DIM, so the 5-bit
  // product never overflows.
  assign target    = 5'(dim_x[4:0] * dim_y[4:0]);
  assign last_elem = ((elem_count + 5'd1) == target);

  assign dims_ok = (bus.dimXIn != 8'd0) && (bus.dimXIn <= 8'(MAX_DIM)) &&
                   (bus.dimYIn != 8'd0) && (bus.dimYIn <= 8'(MAX_DIM));

  assign elem_bad = RANGE_CHECK && (bus.elemData > ELEM_WIDTH'(MAX_VAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    load_start    = 1'b0;
    set_dim_err   = 1'b0;
    set_range_err = 1'b0;
    store_elem    = 1'b0;
    clear_count   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load_start = 1'b1;
          if (dims_ok) begin
            state_next = S_COLLECT;
          end else begin
            set_dim_err = 1'b1;
            state_next  = S_ERROR;
          end
        end
      end
      S_COLLECT: begin
        // abort wins over an element offered in the same cycle
        if (bus.abort) begin
          clear_count = 1'b1;
          state_next  = S_IDLE;
        end else if (bus.elemValid) begin
          if (elem_bad) begin
            set_range_err = 1'b1;
            state_next    = S_ERROR;
          end else begin
            store_elem = 1'b1;
            if (last_elem) begin
              state_next = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: state_next = S_IDLE;
      S_ERROR:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_x      <= '0;
      dim_y      <= '0;
      elem_count <= '0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      if (load_start) begin
        dim_x      <= bus.dimXIn;
        dim_y      <= bus.dimYIn;
        data_q     <= '0;
        elem_count <= '0;
        err_q      <= set_dim_err ? 2'd1 : 2'd0;
      end
      if (clear_count) begin
        elem_count <= '0;
      end
      if (store_elem) begin
        for (int k = 0; k < MAX_ELEM; k++) begin
          if (elem_count == 5'(k)) begin
            data_q[k*ELEM_WIDTH +: ELEM_WIDTH] <= bus.elemData;
          end
        end
        elem_count <= elem_count + 5'd1;
      end
      if (set_range_err) begin
        err_q <= 2'd2;
      end
    end
  end

  assign bus.elemReady   = (state == S_COLLECT);
  assign bus.writeEnable = (state == S_COMMIT);
  assign bus.busy        = (state == S_COLLECT) || (state == S_COMMIT);
  assign bus.dimX        = dim_x;
  assign bus.dimY        = dim_y;
  assign bus.writeData   = data_q;
  assign bus.elemCount   = elem_count;
  assign bus.errCode     = err_q;

endmodule

// File: tb/tb_matrix_entry_assembler.sv
module tb_matrix_entry_assembler;

`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  matrix_entry_if bus();

  matrix_entry_assembler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int we_count = 0;
  int we_last_cyc = 0;
  int we_prev_cyc = 0;

  logic [7:0] elems [25];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.writeEnable === 1'b1) begin
      we_count++;
      we_prev_cyc = we_last_cyc;
      we_last_cyc = cyc;
    end
  end

  // Expected packed word: first n elements in row-major slots, all others zero.
  function automatic logic [199:0] pack_model(input int n);
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = elems[k];
    return r;
  endfunction

  function automatic logic [7:0] rand_elem();
    return RC ? 8'($urandom_range(9)) : 8'($urandom_range(255));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a matrix and offers elems[0..n-1]; returns after the last offer's edge.
  task automatic drive_matrix(input logic [7:0] dx, input logic [7:0] dy, input int n,
                              input int gap_pct, input bit noise,
                              output int not_ready, output logic we_after_last);
    not_ready = 0;
    bus.start = 1'b1;
    bus.dimXIn = dx;
    bus.dimYIn = dy;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      int gaps;
      gaps = ($urandom_range(99) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.elemValid = 1'b0;
        if (noise) begin
          bus.start = 1'b1;
          bus.dimXIn = 8'($urandom_range(255));
          bus.dimYIn = 8'($urandom_range(255));
        end
        tick();
        bus.start = 1'b0;
      end
      bus.elemValid = 1'b1;
      bus.elemData = elems[k];
      if (bus.elemReady !== 1'b1) not_ready++;
      tick();
    end
    bus.elemValid = 1'b0;
    we_after_last = bus.writeEnable;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dimXIn = '0; bus.dimYIn = '0; bus.abort = 1'b0;
    bus.elemValid = 1'b0; bus.elemData = '0;
    #12;
    checks++; if (bus.writeEnable !== 1'b0 || bus.elemReady !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_ctrl got we=%b rdy=%b busy=%b exp 0 0 0", bus.writeEnable, bus.elemReady, bus.busy);
    else passed++;
    checks++; if (bus.dimX !== 8'd0 || bus.dimY !== 8'd0 || bus.elemCount !== 5'd0 || bus.errCode !== 2'd0)
      $display("FAIL reset_status got x=%0d y=%0d cnt=%0d err=%0d exp all 0", bus.dimX, bus.dimY, bus.elemCount, bus.errCode);
    else passed++;
    checks++; if (bus.writeData !== 200'd0)
      $display("FAIL reset_data got %h exp 0", bus.writeData);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int nr; logic we; int w0;
    for (int k = 0; k < 6; k++) elems[k] = 8'(k + 1);
    w0 = we_count;
    drive_matrix(8'd2, 8'd3, 6, 0, 1'b0, nr, we);
    checks++; if (nr !== 0) $display("FAIL basic_ready got not_ready=%0d exp 0", nr); else passed++;
    checks++; if (we !== 1'b1) $display("FAIL basic_latency got we=%b exp 1", we); else passed++;
    checks++; if (bus.writeData !== pack_model(6))
      $display("FAIL basic_data got %h exp %h", bus.writeData, pack_model(6));
    else passed++;
    checks++; if (bus.dimX !== 8'd2 || bus.dimY !== 8'd3 || bus.elemCount !== 5'd6)
      $display("FAIL basic_dims got x=%0d y=%0d cnt=%0d exp 2 3 6", bus.dimX, bus.dimY, bus.elemCount);
    else passed++;
    tick();
    checks++; if (bus.writeEnable !== 1'b0 || bus.busy !== 1'b0 || we_count - w0 !== 1)
      $display("FAIL basic_single_strobe got we=%b busy=%b strobes=%0d exp 0 0 1", bus.writeEnable, bus.busy, we_count - w0);
    else passed++;
    checks++; if (bus.writeData !== pack_model(6))
      $display("FAIL basic_hold got %h exp %h", bus.writeData, pack_model(6));
    else passed++;
  endtask

  task automatic test_bad_dims();
    logic [7:0] bx [5] = '{8'd6, 8'd0, 8'd3, 8'd255, 8'd5};
    logic [7:0] by [5] = '{8'd1, 8'd3, 8'd0, 8'd2,   8'd6};
    int nr; logic we; int w0;
    for (int i = 0; i < 5; i++) begin
      w0 = we_count;
      bus.start = 1'b1; bus.dimXIn = bx[i]; bus.dimYIn = by[i];
      tick();
      bus.start = 1'b0;
      bus.elemValid = 1'b1; bus.elemData = 8'd1;
      checks++; if (bus.errCode !== 2'd1 || bus.elemReady !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL bad_dims_%0d got err=%0d rdy=%b busy=%b exp 1 0 0", i, bus.errCode, bus.elemReady, bus.busy);
      else passed++;
      tick();
      bus.elemValid = 1'b0;
      checks++; if (bus.errCode !== 2'd1 || bus.elemReady !== 1'b0 || we_count !== w0)
        $display("FAIL bad_dims_sticky_%0d got err=%0d rdy=%b strobes=%0d exp 1 0 0", i, bus.errCode, bus.elemReady, we_count - w0);
      else passed++;
      elems[0] = rand_elem();
      drive_matrix(8'd1, 8'd1, 1, 0, 1'b0, nr, we);
      checks++; if (we !== 1'b1 || nr !== 0 || bus.errCode !== 2'd0)
        $display("FAIL bad_dims_recover_%0d got we=%b nr=%0d err=%0d exp 1 0 0", i, we, nr, bus.errCode);
      else passed++;
      tick();
    end
  endtask

  task automatic test_full_gaps();
    int nr; logic we; int w0;
    for (int k = 0; k < 25; k++) elems[k] = rand_elem();
    w0 = we_count;
    drive_matrix(8'd5, 8'd5, 25, 50, 1'b1, nr, we);
    checks++; if (nr !== 0 || we !== 1'b1)
      $display("FAIL full_handshake got nr=%0d we=%b exp 0 1", nr, we);
    else passed++;
    checks++; if (bus.elemCount !== 5'd25 || bus.dimX !== 8'd5 || bus.dimY !== 8'd5)
      $display("FAIL full_count got cnt=%0d x=%0d y=%0d exp 25 5 5", bus.elemCount, bus.dimX, bus.dimY);
    else passed++;
    checks++; if (bus.writeData !== pack_model(25))
      $display("FAIL full_data got %h exp %h", bus.writeData, pack_model(25));
    else passed++;
    tick();
    checks++; if (we_count - w0 !== 1) $display("FAIL full_strobes got %0d exp 1", we_count - w0); else passed++;
  endtask

  task automatic test_abort();
    int nr; logic we; int w0;
    for (int k = 0; k < 9; k++) elems[k] = rand_elem();
    w0 = we_count;
    drive_matrix(8'd3, 8'd3, 4, 20, 1'b0, nr, we);
    checks++; if (we !== 1'b0 || bus.elemCount !== 5'd4 || bus.busy !== 1'b1)
      $display("FAIL abort_pre got we=%b cnt=%0d busy=%b exp 0 4 1", we, bus.elemCount, bus.busy);
    else passed++;
    bus.abort = 1'b1; bus.elemValid = 1'b1; bus.elemData = 8'd7;
    tick();
    bus.abort = 1'b0; bus.elemValid = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.elemCount !== 5'd0 || bus.elemReady !== 1'b0)
      $display("FAIL abort_state got busy=%b cnt=%0d rdy=%b exp 0 0 0", bus.busy, bus.elemCount, bus.elemReady);
    else passed++;
    repeat (3) tick();
    checks++; if (we_count !== w0) $display("FAIL abort_no_strobe got %0d exp 0", we_count - w0); else passed++;
    for (int k = 0; k < 9; k++) elems[k] = rand_elem();
    drive_matrix(8'd3, 8'd3, 9, 20, 1'b0, nr, we);
    checks++; if (we !== 1'b1 || bus.writeData !== pack_model(9) || bus.elemCount !== 5'd9)
      $display("FAIL abort_next got we=%b cnt=%0d data=%h exp 1 9 %h", we, bus.elemCount, bus.writeData, pack_model(9));
    else passed++;
    tick();
  endtask

  task automatic test_range();
    int nr; logic we; int w0;
    elems[0] = 8'd3; elems[1] = 8'd12; elems[2] = 8'd7; elems[3] = 8'd200;
    w0 = we_count;
`ifdef RANGE_CHECK_EN
    drive_matrix(8'd2, 8'd2, 2, 0, 1'b0, nr, we);
    checks++; if (bus.errCode !== 2'd2 || bus.busy !== 1'b0 || bus.elemReady !== 1'b0)
      $display("FAIL range_err got err=%0d busy=%b rdy=%b exp 2 0 0", bus.errCode, bus.busy, bus.elemReady);
    else passed++;
    checks++; if (bus.writeData[15:8] !== 8'd0)
      $display("FAIL range_not_stored got %0d exp 0", bus.writeData[15:8]);
    else passed++;
    tick();
    checks++; if (bus.errCode !== 2'd2 || we_count !== w0)
      $display("FAIL range_sticky got err=%0d strobes=%0d exp 2 0", bus.errCode, we_count - w0);
    else passed++;
    elems[0] = 8'd9; elems[1] = 8'd0; elems[2] = 8'd9; elems[3] = 8'd8;
    drive_matrix(8'd2, 8'd2, 4, 0, 1'b0, nr, we);
    checks++; if (we !== 1'b1 || bus.errCode !== 2'd0 || bus.writeData !== pack_model(4))
      $display("FAIL range_boundary got we=%b err=%0d data=%h exp 1 0 %h", we, bus.errCode, bus.writeData, pack_model(4));
    else passed++;
`else
    drive_matrix(8'd2, 8'd2, 4, 0, 1'b0, nr, we);
    checks++; if (we !== 1'b1 || bus.errCode !== 2'd0)
      $display("FAIL range_off got we=%b err=%0d exp 1 0", we, bus.errCode);
    else passed++;
    checks++; if (bus.writeData !== pack_model(4))
      $display("FAIL range_off_data got %h exp %h", bus.writeData, pack_model(4));
    else passed++;
`endif
    tick();
  endtask

  task automatic test_random();
    int nr; logic we; int w0; int dx; int dy;
    for (int it = 0; it < 10; it++) begin
      dx = int'($urandom_range(5, 1));
      dy = int'($urandom_range(5, 1));
      for (int k = 0; k < 25; k++) elems[k] = rand_elem();
      w0 = we_count;
      drive_matrix(8'(dx), 8'(dy), dx * dy, 30, 1'b1, nr, we);
      checks++; if (we !== 1'b1 || nr !== 0)
        $display("FAIL rand_%0d_commit got we=%b nr=%0d exp 1 0", it, we, nr);
      else passed++;
      checks++; if (bus.writeData !== pack_model(dx * dy) || bus.dimX !== 8'(dx) || bus.dimY !== 8'(dy))
        $display("FAIL rand_%0d_data dims %0dx%0d got %h exp %h", it, dx, dy, bus.writeData, pack_model(dx * dy));
      else passed++;
      tick();
      checks++; if (we_count - w0 !== 1 || bus.busy !== 1'b0)
        $display("FAIL rand_%0d_strobe got strobes=%0d busy=%b exp 1 0", it, we_count - w0, bus.busy);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int nr; logic we;
    elems[0] = rand_elem(); elems[1] = rand_elem();
    drive_matrix(8'd2, 8'd1, 2, 0, 1'b0, nr, we);
    // start held through COMMIT must not be taken until IDLE
    bus.start = 1'b1; bus.dimXIn = 8'd1; bus.dimYIn = 8'd1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.dimX !== 8'd2)
      $display("FAIL b2b_commit_ignores_start got busy=%b x=%0d exp 0 2", bus.busy, bus.dimX);
    else passed++;
    elems[0] = rand_elem();
    drive_matrix(8'd1, 8'd1, 1, 0, 1'b0, nr, we);
    checks++; if (we !== 1'b1 || bus.writeData !== pack_model(1))
      $display("FAIL b2b_second got we=%b data=%h exp 1 %h", we, bus.writeData, pack_model(1));
    else passed++;
    tick();
    checks++; if (we_last_cyc - we_prev_cyc !== 3)
      $display("FAIL b2b_spacing got %0d exp 3", we_last_cyc - we_prev_cyc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int nr; logic we; int w0;
    for (int k = 0; k < 9; k++) elems[k] = rand_elem();
    w0 = we_count;
    drive_matrix(8'd3, 8'd3, 4, 0, 1'b0, nr, we);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.elemReady !== 1'b0 || bus.writeEnable !== 1'b0 ||
                  bus.elemCount !== 5'd0 || bus.dimX !== 8'd0 || bus.dimY !== 8'd0 ||
                  bus.errCode !== 2'd0 || bus.writeData !== 200'd0)
      $display("FAIL reset_mid got busy=%b rdy=%b cnt=%0d x=%0d data=%h exp all 0", bus.busy, bus.elemReady, bus.elemCount, bus.dimX, bus.writeData);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (we_count !== w0 || bus.busy !== 1'b0)
      $display("FAIL reset_mid_after got strobes=%0d busy=%b exp 0 0", we_count - w0, bus.busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_dims();
    test_full_gaps();
    test_abort();
    test_range();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
